// File: rtl/clk_rst_seq.sv
// Clock-enable / staggered-reset sequencer fed by the MMCM wrapper clock and LOCKED.
// Waits for a stable lock, releases channels one by one, and re-sequences on lock loss or soft_rst.

module clk_rst_seq_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst_i,
  input  logic             rst_nxt_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d, hit;

  // Ratios 0 and 1 both mean "enable every cycle".
  always_comb begin
    hit   = (div_i <= ONE) || (cnt_q == div_i - ONE);
    cnt_d = (rst_i || rst_nxt_i || hit) ? '0 : cnt_q + ONE;
    ce_d  = !rst_i && !rst_nxt_i && hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;
endmodule

module clk_rst_seq #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_WAIT = 1024,
  parameter int STAGGER   = 16,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked,
  input  logic                    soft_rst,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    ready,
  output logic [CNT_W-1:0]        lock_loss_cnt
);
  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SW-1:0] LW_M1 = SW'(LOCK_WAIT - 1);
  localparam logic [GW-1:0] ST_M1 = GW'(STAGGER - 1);
  localparam logic [CW-1:0] NC_M1 = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sync_q;
  logic [SW-1:0]             stable_q, stable_d;
  logic [GW-1:0]             stag_q, stag_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [NUM_CH-1:0]         rst_q, rst_d;
  logic                      ready_q, ready_d;
  logic [NUM_CH*DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]          llc_q, llc_d;
  logic                      locked_s, abort;

  assign locked_s = sync_q[1];
  assign abort    = ((state_q == RELEASE) || (state_q == RUN)) && (!locked_s || soft_rst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      stable_q <= '0;
      stag_q   <= '0;
      ch_q     <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      div_q    <= '0;
      llc_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], locked};
      stable_q <= stable_d;
      stag_q   <= stag_d;
      ch_q     <= ch_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      div_q    <= div_d;
      llc_q    <= llc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (locked_s) state_d = STABLE;
      STABLE: begin
        if (!locked_s)                           state_d = WAIT_LOCK;
        else if (!soft_rst && stable_q == LW_M1) state_d = RELEASE;
      end
      RELEASE: begin
        if (abort)                                 state_d = WAIT_LOCK;
        else if (stag_q == ST_M1 && ch_q == NC_M1) state_d = RUN;
      end
      RUN:     if (abort) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    rst_d    = rst_q;
    ready_d  = ready_q;
    stable_d = stable_q;
    stag_d   = stag_q;
    ch_d     = ch_q;
    div_d    = div_q;
    llc_d    = llc_q;
    case (state_q)
      WAIT_LOCK: begin
        rst_d    = '1;
        ready_d  = 1'b0;
        stable_d = '0;
      end
      STABLE: begin
        if (!locked_s || soft_rst) stable_d = '0;
        else if (stable_q == LW_M1) begin
          rst_d[0] = 1'b0;
          ch_d     = '0;
          stag_d   = '0;
          div_d    = div_ratio;
        end else stable_d = stable_q + SW'(1);
      end
      RELEASE: begin
        if (!abort) begin
          if (stag_q == ST_M1) begin
            stag_d = '0;
            if (ch_q != NC_M1) begin
              ch_d = ch_q + CW'(1);
              for (int k = 0; k < NUM_CH; k++)
                if (ch_d == CW'(k)) rst_d[k] = 1'b0;
            end else ready_d = 1'b1;
          end else stag_d = stag_q + GW'(1);
        end
      end
      default: ;
    endcase
    // Only a real lock loss is counted; a coincident soft_rst does not add a second count.
    if (abort) begin
      rst_d   = '1;
      ready_d = 1'b0;
      if (!locked_s && llc_q != {CNT_W{1'b1}}) llc_d = llc_q + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_rst_seq_ch #(.DIV_W(DIV_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .rst_i     (rst_q[i]),
      .rst_nxt_i (rst_d[i]),
      .div_i     (div_q[i*DIV_W +: DIV_W]),
      .ce_o      (ce_out[i])
    );
  end

  assign rst_out       = rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = llc_q;
endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: stimulus queues expected output snapshots per cycle,
// an independent monitor compares them at the falling edge.

module tb_clk_rst_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        soft_rst = 1'b0;
  logic [23:0] div_ratio = {8'd0, 8'd3, 8'd1};
  logic [2:0]  rst_out, ce_out;
  logic        ready;
  logic [1:0]  lock_loss_cnt;

  clk_rst_seq #(.NUM_CH(3), .DIV_W(8), .LOCK_WAIT(8), .STAGGER(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst(soft_rst), .div_ratio(div_ratio),
    .rst_out(rst_out), .ce_out(ce_out), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic [2:0] ce;
    logic       rdy;
    logic [1:0] llc;
    bit         chk_ce;
    int         ph;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input int c, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got {rst,ce,rdy,llc}=%b exp=%b", nm, c, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] r, input logic [2:0] ce, input logic rdy,
                      input logic [1:0] llc, input bit chk, input int ph);
    exp_t e;
    e.cyc = c; e.rst = r; e.ce = ce; e.rdy = rdy; e.llc = llc; e.chk_ce = chk; e.ph = ph;
    q.push_back(e);
  endtask

  // Release timeline with LOCK_WAIT=8, STAGGER=4: locked first sampled high at edge t.
  task automatic push_seq(input int t, input logic [1:0] llc, input int d1, input int last, input int ph);
    for (int c = t + 8; c <= last && c <= t + 28; c++) begin
      logic [2:0] r, ce;
      r     = {c < t + 18, c < t + 14, c < t + 10};
      ce[0] = (c >= t + 11);
      ce[1] = (c > t + 14) && (((c - t - 14) % d1) == 0);
      ce[2] = (c >= t + 19);
      push(c, r, ce, c >= t + 22, llc, 1'b1, ph);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: independent of stimulus, compares whatever is due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [2:0] m;
      e = q.pop_front();
      m = e.chk_ce ? 3'b111 : 3'b000;
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_p%0d cyc=%0d now=%0d", e.ph, e.cyc, cyc);
      end else
        check($sformatf("snap_p%0d", e.ph), cyc,
              {rst_out, ce_out & m, ready, lock_loss_cnt},
              {e.rst, e.ce & m, e.rdy, e.llc});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, tg, n;
    logic [1:0] llc;
    @(negedge clk);
    // Reset state
    push(cyc + 1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b1, 0);
    wait_until(3);
    rst_n = 1'b1;
    // Lock glitch in STABLE: no release, restart once locked_s returns
    wait_until(5);
    locked = 1'b1;
    t = cyc + 1;
    tg = t + 8;
    push(t + 7,  3'b111, 3'b000, 1'b0, 2'd0, 1'b1, 1);
    push(t + 10, 3'b111, 3'b000, 1'b0, 2'd0, 1'b1, 1);
    push(t + 12, 3'b111, 3'b000, 1'b0, 2'd0, 1'b1, 1);
    push_seq(tg, 2'd0, 3, tg + 24, 1);
    wait_until(t + 4);
    locked = 1'b0;
    wait_until(t + 7);
    locked = 1'b1;
    wait_until(tg + 24);
    // Clean power-up from reset
    rst_n = 1'b0;
    locked = 1'b0;
    push(cyc + 1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b1, 2);
    wait_until(cyc + 2);
    rst_n = 1'b1;
    wait_until(cyc + 2);
    locked = 1'b1;
    t = cyc + 1;
    push_seq(t, 2'd0, 3, t + 28, 2);
    wait_until(t + 28);
    // Lock loss in RUN
    n = cyc;
    locked = 1'b0;
    push(n + 2, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 3);
    push(n + 3, 3'b111, 3'b000, 1'b0, 2'd1, 1'b1, 3);
    wait_until(n + 5);
    locked = 1'b1;
    t = cyc + 1;
    push_seq(t, 2'd1, 3, t + 15, 3);
    // soft_rst after ch1 released; new ch1 ratio takes effect on the next latch
    wait_until(t + 15);
    soft_rst = 1'b1;
    div_ratio[15:8] = 8'd5;
    push(t + 16, 3'b111, 3'b000, 1'b0, 2'd1, 1'b1, 4);
    wait_until(t + 16);
    soft_rst = 1'b0;
    t = t + 15;
    push_seq(t, 2'd1, 5, t + 28, 4);
    wait_until(t + 28);
    // Four more losses: counter saturates at 3
    llc = 2'd1;
    for (int i = 0; i < 4; i++) begin
      n = cyc;
      locked = 1'b0;
      if (llc != 2'd3) llc = llc + 2'd1;
      push(n + 3, 3'b111, 3'b000, 1'b0, llc, 1'b1, 5);
      wait_until(n + 5);
      locked = 1'b1;
      t = cyc + 1;
      push_seq(t, llc, 5, t + 28, 5);
      wait_until(t + 28);
    end
    // Async reset mid-RUN, checked before any clock edge
    #2 rst_n = 1'b0;
    #1 check("async_rst", cyc, {rst_out, ce_out, ready, lock_loss_cnt}, {3'b111, 3'b000, 1'b0, 2'd0});
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain left=%0d", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Parametrised clock-enable and reset sequencer. It sits directly downstream of the board MMCM clock wrapper and consumes that wrapper's output clock and LOCKED status.
- Generates NUM_CH staggered synchronous resets and NUM_CH programmable-ratio clock enables for the static and reconfigurable partitions.
- Re-sequences automatically on lock loss or on software request, and counts lock-loss events.

Parameters:
- NUM_CH, 4, number of reset/clock-enable channels (1..16).
- DIV_W, 8, width of each per-channel divide ratio.
- LOCK_WAIT, 1024, cycles locked_s must stay high before the first release (>=2).
- STAGGER, 16, cycles between successive channel releases (>=1).
- CNT_W, 8, width of the lock-loss counter.

Ports:
- clk  in  1  system clock (MMCM output, post-BUFG).
- rst_n  in  1  asynchronous active-low reset.
- locked  in  1  MMCM LOCKED, asynchronous to clk.
- soft_rst  in  1  synchronous one-cycle re-sequence request.
- div_ratio  in  NUM_CH*DIV_W  divide ratio; channel i at bits [i*DIV_W +: DIV_W].
- rst_out  out  NUM_CH  active-high synchronous reset per channel.
- ce_out  out  NUM_CH  clock-enable per channel.
- ready  out  1  all channels released and running.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses after release began.

Behaviour:
- Reset (rst_n=0, async):
  - rst_out = all 1, ce_out = 0, ready = 0, lock_loss_cnt = 0, state = WAIT_LOCK, all counters = 0.
  - Deassertion takes effect on the next clk edge.
- Lock synchroniser: locked passes through a 2-flop synchroniser to give locked_s; 2-cycle latency. All decisions use locked_s only.
- States: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK:
  - rst_out all 1, ce_out 0, ready 0.
  - locked_s=1 -> STABLE, stable_cnt=0.
- STABLE:
  - stable_cnt increments each cycle.
  - locked_s=0 -> WAIT_LOCK (not counted).
  - stable_cnt==LOCK_WAIT-1 -> RELEASE. On the same edge: rst_out[0]<=0, ch_idx=0, stag_cnt=0, div_ratio latched into div_q.
- RELEASE:
  - stag_cnt increments each cycle.
  - stag_cnt==STAGGER-1 and ch_idx<NUM_CH-1: ch_idx++, rst_out[ch_idx+1]<=0, stag_cnt=0.
  - stag_cnt==STAGGER-1 and ch_idx==NUM_CH-1: -> RUN, ready<=1.
  - Channel k releases k*STAGGER cycles after channel 0; ready asserts NUM_CH*STAGGER cycles after channel 0.
  - NUM_CH=1: ready asserts STAGGER cycles after rst_out[0] falls.
- RUN: holds until abort.
- Abort (locked_s=0 or soft_rst=1 while in RELEASE or RUN):
  - Next edge: rst_out all 1, ce_out 0, ready 0, state WAIT_LOCK.
  - lock_loss_cnt increments only on locked_s loss, saturating at 2^CNT_W-1.
  - soft_rst is never counted.
  - If both occur in the same cycle, count once.
- soft_rst in WAIT_LOCK or STABLE:
  - STABLE: stable_cnt restarts at 0.
  - WAIT_LOCK: no effect.
- Clock enables, per channel i, with D=div_q[i]:
  - div_cnt[i] is held 0 while rst_out[i]=1.
  - D=0 or D=1: ce_out[i]=1 every cycle starting the cycle after rst_out[i] falls.
  - D>=2: div_cnt counts 0..D-1 and wraps. ce_out[i] is registered, high for exactly one cycle when div_cnt==D-1. First pulse occurs D cycles after rst_out[i] falls; period is D cycles.
  - div_ratio changes after latch are ignored until the next STABLE->RELEASE transition.
- All outputs are registered; no combinational path from any input to any output.

Test Plan (NUM_CH=3, LOCK_WAIT=8, STAGGER=4, DIV_W=8, CNT_W=2, div_ratio = ch0 1, ch1 3, ch2 0):
- Power-up sequence:
  - Stimulus: rst_n low then high, locked rises at cycle T.
  - Response: STABLE entered at T+2. rst_out[0] falls at T+10, rst_out[1] at T+14, rst_out[2] at T+18. ready=1 at T+22. ce_out[0] and ce_out[2] constant 1 after release. ce_out[1] pulses every 3 cycles, first at T+17.
- Lock glitch during STABLE:
  - Stimulus: locked low for 3 cycles at T+5.
  - Response: no release occurs, lock_loss_cnt stays 0, sequence restarts and completes 8 cycles after locked_s returns high.
- Lock loss in RUN:
  - Stimulus: locked drops after ready.
  - Response: 3 cycles after the drop (2 synchroniser + 1), rst_out=3'b111, ce_out=0, ready=0, lock_loss_cnt=1. Full resequence on relock.
- Counter saturation:
  - Stimulus: 5 lock losses in RUN.
  - Response: lock_loss_cnt=3 and holds.
- soft_rst in RELEASE:
  - Stimulus: soft_rst after ch1 released.
  - Response: all resets reassert next cycle, lock_loss_cnt unchanged, resequence starts 8 cycles later. div_ratio changed to ch1=5 before the new release is latched: ce_out[1] period becomes 5.
- Async reset mid-RUN:
  - Stimulus: rst_n low without a clock edge.
  - Response: outputs go to reset values immediately; lock_loss_cnt=0.
